if_fetch_stage: RTL and testbench



---
 rtl/if_fetch_stage_pkg.sv | 38 +++
 rtl/if_fetch_stage_if.sv | 44 ++++
 rtl/if_fetch_stage_inst_fifo.sv | 64 ++++++
 rtl/if_fetch_stage.sv | 92 +++++++++
 tb/tb_if_fetch_stage.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package if_fetch_stage_pkg;

    localparam int XLEN       = 32;
    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);

    // addi x0,x0,0: presented whenever there is no real instruction to hand out
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,   // free to issue a request
        IF_WAIT = 2'd1,   // one request outstanding, response wanted
        IF_DROP = 2'd2    // one request outstanding, response is stale
    } if_state_t;

    // Buffered fetch result, laid out {fault, pc, inst}
    typedef struct packed {
        logic            fault;
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } fetch_entry_t;

    // A faulted entry never carries the raw bus word, so decode sees a harmless NOP
    function automatic fetch_entry_t make_entry(input logic fault,
                                                input logic [XLEN-1:0] pc,
                                                input logic [31:0] word);
        fetch_entry_t e;
        e.fault = fault;
        e.pc    = pc;
        e.inst  = fault ? NOP_INST : word;
        return e;
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Bundle of PC-generator, instruction-memory and decode-side signals of the fetch stage.
// Latency: n/a (wiring only).
// Backpressure: gnt for requests, id_ready_i for the instruction head.
interface if_fetch_stage_if;
    import if_fetch_stage_pkg::*;

    logic            enable_design;
    logic [XLEN-1:0] pc_i;
    logic            pc_valid_i;
    logic            flush_i;
    logic            stage_IF_ready;

    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_gnt_i;
    logic            imem_rvalid_i;
    logic [31:0]     imem_rdata_i;
    logic            imem_err_i;

    logic            inst_valid_o;
    logic [31:0]     inst_o;
    logic [XLEN-1:0] inst_pc_o;
    logic            inst_fault_o;
    logic            id_ready_i;

    // Fetch stage side
    modport master (
        input  enable_design, pc_i, pc_valid_i, flush_i,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, imem_err_i,
        input  id_ready_i,
        output stage_IF_ready, imem_req_o, imem_addr_o,
        output inst_valid_o, inst_o, inst_pc_o, inst_fault_o
    );

    // Environment side: PC generator, instruction memory, decode
    modport slave (
        output enable_design, pc_i, pc_valid_i, flush_i,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, imem_err_i,
        output id_ready_i,
        input  stage_IF_ready, imem_req_o, imem_addr_o,
        input  inst_valid_o, inst_o, inst_pc_o, inst_fault_o
    );

endinterface

// File: rtl/if_fetch_stage_inst_fifo.sv
// 2-entry buffer of fetched instructions with their PC and fault flag, plus flush.
// Latency: push visible at the head the cycle after; head is combinational from state.
// Backpressure: pop only when head valid; producer must hold off pushing when full.
module if_inst_fifo
    import if_fetch_stage_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             push_vld,
    input  fetch_entry_t     push_dat,
    input  logic             pop_rdy,
    output logic             head_vld,
    output fetch_entry_t     head_dat,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             pop_eff;
    logic             push_eff;

    assign head_vld = (count != '0);
    assign pop_eff  = pop_rdy & head_vld;
    assign push_eff = push_vld & ~flush_i;

    // Pointer and occupancy tracking; flush wins over any same-cycle push or pop
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_eff)
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop_eff)
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CNT_W'(push_eff) - CNT_W'(pop_eff);
        end
    end

    // Storage needs no reset: nothing is read out while count is zero
    always_ff @(posedge clk_i) begin
        if (push_eff)
            mem[wr_ptr] <= push_dat;
    end

    // Empty head reads as a clean NOP at PC 0 so decode never sees stale data
    always_comb begin
        head_dat = make_entry(1'b0, '0, NOP_INST);
        if (head_vld)
            head_dat = mem[rd_ptr];
    end

    // Single outstanding request plus issue gating on count means a full push is a bug
    assert property (@(posedge clk_i) disable iff (reset_i)
                     !(push_eff && count == CNT_W'(FIFO_DEPTH)));

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: turns the current PC into one imem request at a time and buffers results.
// Latency: grant in N, rvalid in N+1 -> head valid in N+2; peak one fetch per 2 cycles.
// Backpressure: no issue while the buffer is full or a request is outstanding.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    if_fetch_stage_if.master  bus
);

    if_state_t        state;
    logic [XLEN-1:0]  req_pc_r;
    logic [CNT_W-1:0] count;
    logic             issue_ok;
    logic             aligned;
    logic             in_idle;
    logic             push_vld;
    fetch_entry_t     push_dat;
    fetch_entry_t     head_dat;
    logic             head_vld;

    // Reset also blocks issue so the request line is low while reset is held
    assign issue_ok = ~reset_i & bus.enable_design & bus.pc_valid_i & ~bus.flush_i
                      & (count < CNT_W'(FIFO_DEPTH));
    assign aligned  = (bus.pc_i[1:0] == 2'b00);
    assign in_idle  = (state == IF_IDLE);

    assign bus.imem_req_o     = in_idle & issue_ok & aligned;
    assign bus.imem_addr_o    = bus.pc_i;
    // A misaligned PC is consumed immediately as a fault, no bus traffic needed
    assign bus.stage_IF_ready = in_idle & issue_ok & (aligned ? bus.imem_gnt_i : 1'b1);

    // Choose what enters the buffer: a misaligned-PC fault or a live memory response
    always_comb begin
        push_vld = 1'b0;
        push_dat = make_entry(1'b0, '0, NOP_INST);
        if (in_idle && issue_ok && !aligned) begin
            push_vld = 1'b1;
            push_dat = make_entry(1'b1, bus.pc_i, NOP_INST);
        end else if (state == IF_WAIT && bus.imem_rvalid_i && !bus.flush_i) begin
            push_vld = 1'b1;
            push_dat = make_entry(bus.imem_err_i, req_pc_r, bus.imem_rdata_i);
        end
    end

    // Request FSM: tracks the single outstanding fetch and whether it has gone stale
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state    <= IF_IDLE;
            req_pc_r <= '0;
        end else begin
            case (state)
                IF_IDLE: begin
                    if (bus.imem_req_o && bus.imem_gnt_i) begin
                        req_pc_r <= bus.pc_i;
                        state    <= IF_WAIT;
                    end
                end
                IF_WAIT: begin
                    if (bus.imem_rvalid_i)
                        state <= IF_IDLE;
                    else if (bus.flush_i)
                        state <= IF_DROP;
                end
                IF_DROP: begin
                    if (bus.imem_rvalid_i)
                        state <= IF_IDLE;
                end
                default: state <= IF_IDLE;
            endcase
        end
    end

    if_inst_fifo u_fifo (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .flush_i  (bus.flush_i),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_rdy  (bus.id_ready_i),
        .head_vld (head_vld),
        .head_dat (head_dat),
        .count    (count)
    );

    assign bus.inst_valid_o = head_vld;
    assign bus.inst_o       = head_dat.inst;
    assign bus.inst_pc_o    = head_dat.pc;
    assign bus.inst_fault_o = head_dat.fault;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for the fetch stage: inputs change on the falling edge, outputs checked 1ns later.
// Latency: n/a.
// Backpressure: exercised through id_ready_i and a held-off grant.
module tb_if_fetch_stage;

    logic clk_i = 1'b0;
    logic reset_i;
    int   n_chk  = 0;
    int   n_pass = 0;

    if_fetch_stage_if bus();

    if_fetch_stage dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Advance one full cycle, landing on the next falling edge
    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic chk_head(input string tag, input logic vld, input logic [31:0] pc,
                            input logic [31:0] inst, input logic fault);
        chk({tag, ".vld"},   32'(bus.inst_valid_o), 32'(vld));
        chk({tag, ".pc"},    bus.inst_pc_o, pc);
        chk({tag, ".inst"},  bus.inst_o, inst);
        chk({tag, ".fault"}, 32'(bus.inst_fault_o), 32'(fault));
    endtask

    initial begin
        reset_i           = 1'b1;
        bus.enable_design = 1'b1;
        bus.pc_i          = 32'h100;
        bus.pc_valid_i    = 1'b1;
        bus.flush_i       = 1'b0;
        bus.imem_gnt_i    = 1'b1;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'h0;
        bus.imem_err_i    = 1'b0;
        bus.id_ready_i    = 1'b0;

        // Reset values, even with a valid PC and grant presented
        @(negedge clk_i);
        #1;
        chk_head("rst", 1'b0, 32'h0, 32'h13, 1'b0);
        chk("rst.req",   32'(bus.imem_req_o), 32'd0);
        chk("rst.ready", 32'(bus.stage_IF_ready), 32'd0);
        @(negedge clk_i);
        reset_i = 1'b0;

        // 1: straight line 0x100, 0x104 with 1-cycle memory
        #1;
        chk("t1.req0",   32'(bus.imem_req_o), 32'd1);
        chk("t1.addr0",  bus.imem_addr_o, 32'h100);
        chk("t1.rdy0",   32'(bus.stage_IF_ready), 32'd1);
        step();
        bus.pc_i = 32'h104; bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'hAAAA_0001;
        #1;
        chk("t1.req_wait", 32'(bus.imem_req_o), 32'd0);
        chk("t1.rdy_wait", 32'(bus.stage_IF_ready), 32'd0);
        chk("t1.vld_n1",   32'(bus.inst_valid_o), 32'd0);
        step();
        bus.imem_rvalid_i = 1'b0; bus.id_ready_i = 1'b1;
        #1;
        chk_head("t1.h0", 1'b1, 32'h100, 32'hAAAA_0001, 1'b0);
        chk("t1.addr1", bus.imem_addr_o, 32'h104);
        chk("t1.rdy1",  32'(bus.stage_IF_ready), 32'd1);
        step();
        bus.pc_valid_i = 1'b0; bus.imem_gnt_i = 1'b0;
        bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'hBBBB_0002;
        #1;
        chk("t1.vld_pop", 32'(bus.inst_valid_o), 32'd0);
        step();
        bus.imem_rvalid_i = 1'b0;
        #1;
        chk_head("t1.h1", 1'b1, 32'h104, 32'hBBBB_0002, 1'b0);
        step();
        #1;
        chk("t1.drained", 32'(bus.inst_valid_o), 32'd0);

        // 2: redirect while waiting; stale response dropped, then fetch 0x400
        @(negedge clk_i);
        bus.pc_i = 32'h200; bus.pc_valid_i = 1'b1; bus.imem_gnt_i = 1'b1;
        #1;
        chk("t2.rdy200", 32'(bus.stage_IF_ready), 32'd1);
        step();
        bus.imem_gnt_i = 1'b0; bus.flush_i = 1'b1; bus.pc_i = 32'h400;
        #1;
        chk("t2.req_flush", 32'(bus.imem_req_o), 32'd0);
        step();
        bus.flush_i = 1'b0;
        #1;
        chk("t2.req_drop", 32'(bus.imem_req_o), 32'd0);
        chk("t2.rdy_drop", 32'(bus.stage_IF_ready), 32'd0);
        step();
        step();
        bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'hDEAD_BEEF;
        step();
        bus.imem_rvalid_i = 1'b0; bus.imem_gnt_i = 1'b1;
        #1;
        chk("t2.vld_dropped", 32'(bus.inst_valid_o), 32'd0);
        chk("t2.req400",  32'(bus.imem_req_o), 32'd1);
        chk("t2.addr400", bus.imem_addr_o, 32'h400);
        step();
        bus.imem_gnt_i = 1'b0; bus.pc_valid_i = 1'b0;
        bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'h1111_0400;
        step();
        bus.imem_rvalid_i = 1'b0;
        #1;
        chk_head("t2.h", 1'b1, 32'h400, 32'h1111_0400, 1'b0);
        step();

        // 3: backpressure, two entries fill the buffer and no third request
        bus.id_ready_i = 1'b0; bus.pc_i = 32'h500; bus.pc_valid_i = 1'b1; bus.imem_gnt_i = 1'b1;
        step();
        bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'h5555_0000;
        bus.pc_i = 32'h504;
        step();
        bus.imem_rvalid_i = 1'b0; bus.imem_gnt_i = 1'b1;
        step();
        bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'h5555_0004;
        bus.pc_i = 32'h508;
        step();
        bus.imem_rvalid_i = 1'b0; bus.imem_gnt_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("t3.noreq%0d", i), 32'(bus.imem_req_o), 32'd0);
            step();
        end
        bus.pc_valid_i = 1'b0; bus.imem_gnt_i = 1'b0; bus.id_ready_i = 1'b1;
        #1;
        chk_head("t3.h0", 1'b1, 32'h500, 32'h5555_0000, 1'b0);
        step();
        #1;
        chk_head("t3.h1", 1'b1, 32'h504, 32'h5555_0004, 1'b0);
        step();
        #1;
        chk("t3.empty", 32'(bus.inst_valid_o), 32'd0);

        // 4: bus error returns a NOP fault entry at 0x300
        @(negedge clk_i);
        bus.pc_i = 32'h300; bus.pc_valid_i = 1'b1; bus.imem_gnt_i = 1'b1; bus.id_ready_i = 1'b0;
        step();
        bus.pc_valid_i = 1'b0; bus.imem_gnt_i = 1'b0;
        bus.imem_rvalid_i = 1'b1; bus.imem_err_i = 1'b1; bus.imem_rdata_i = 32'h1234_5678;
        step();
        bus.imem_rvalid_i = 1'b0; bus.imem_err_i = 1'b0; bus.id_ready_i = 1'b1;
        #1;
        chk_head("t4.h", 1'b1, 32'h300, 32'h13, 1'b1);
        step();

        // 5: misaligned PC faults without touching the bus
        bus.pc_i = 32'h102; bus.pc_valid_i = 1'b1; bus.id_ready_i = 1'b0;
        #1;
        chk("t5.req", 32'(bus.imem_req_o), 32'd0);
        chk("t5.rdy", 32'(bus.stage_IF_ready), 32'd1);
        step();
        bus.pc_valid_i = 1'b0;
        #1;
        chk("t5.rdy_once", 32'(bus.stage_IF_ready), 32'd0);
        chk_head("t5.h", 1'b1, 32'h102, 32'h13, 1'b1);
        bus.id_ready_i = 1'b1;
        step();

        // 6: asynchronous reset mid-WAIT with a buffered entry, late rvalid ignored
        bus.id_ready_i = 1'b0; bus.pc_i = 32'h106; bus.pc_valid_i = 1'b1; bus.imem_gnt_i = 1'b0;
        step();
        bus.pc_i = 32'h600; bus.imem_gnt_i = 1'b1;
        #1;
        chk("t6.rdy600", 32'(bus.stage_IF_ready), 32'd1);
        step();
        bus.imem_gnt_i = 1'b0; bus.pc_valid_i = 1'b0;
        #1;
        chk("t6.vld_pre", 32'(bus.inst_valid_o), 32'd1);
        #1;
        reset_i = 1'b1;
        #1;
        chk_head("t6.rst", 1'b0, 32'h0, 32'h13, 1'b0);
        chk("t6.rst.req", 32'(bus.imem_req_o), 32'd0);
        @(negedge clk_i);
        reset_i = 1'b0; bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'h6666_0000;
        step();
        bus.imem_rvalid_i = 1'b0; bus.pc_i = 32'h700; bus.pc_valid_i = 1'b1;
        #1;
        chk("t6.late_ignored", 32'(bus.inst_valid_o), 32'd0);
        chk("t6.idle_req",     32'(bus.imem_req_o), 32'd1);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
